addr_reader: RTL
================

Name: addr_reader

Overview:
- Read-side counterpart of the frame-buffer address writer in the VGA system.
- Fetches one scanline of pixel words from SDRAM for display scanout.
- Forms read addresses as {BANK, row, column}, where row = line_y + offset and column steps 0..WORDS_PER_LINE-1.
- Issues requests to the SDRAM controller with a req/ack handshake, buffers in-order returned data in a small FIFO, and streams pixels to the VGA output with a valid/ready handshake.

Parameters:
- ROW_WIDTH, 9, row field width.
- COL_WIDTH, 9, column field width.
- BANK_WIDTH, 2, bank field width.
- BANK, 1, constant bank value placed in the bank field.
- HADDR_WIDTH, BANK_WIDTH+ROW_WIDTH+COL_WIDTH, SDRAM address width.
- DATA_WIDTH, 16, pixel word width.
- WORDS_PER_LINE, 320, words fetched per line; must be ≤ 2^COL_WIDTH.
- FIFO_DEPTH, 8, return-buffer depth; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- line_start  in  1  one-cycle pulse that starts a line fetch.
- line_y  in  10  display line number, sampled on line_start.
- offset  in  10  frame-buffer row offset, sampled on line_start.
- busy  out  1  high from the cycle after an accepted line_start until line_done.
- line_done  out  1  one-cycle pulse when the last word of the line has returned.
- rd_req  out  1  read request to the SDRAM controller.
- rd_addr  out  HADDR_WIDTH  read address, valid while rd_req is high.
- rd_ack  in  1  controller accepts the request in this cycle.
- rd_valid  in  1  returned data is valid this cycle; returns arrive in request order.
- rd_data  in  DATA_WIDTH  returned data.
- pix_valid  out  1  FIFO is not empty.
- pix_data  out  DATA_WIDTH  word at the FIFO head.
- pix_ready  in  1  VGA side consumes the head word when pix_valid is also high.

Behaviour:
- Reset: all outputs are 0. rst clears the state machine, counters, outstanding count and FIFO (pointers and count).
  - rst wins over any simultaneous event.
  - Reset mid-line abandons the line with no line_done.
  - rd_valid arriving after reset, with outstanding = 0, is ignored.
- State IDLE:
  - line_start latches row = (line_y + offset) mod 2^ROW_WIDTH (11-bit sum, truncated).
  - Sets col = 0 and goes to ISSUE.
  - rd_req is first asserted in the cycle after line_start.
- State ISSUE:
  - rd_req = 1 when credit is available: fifo_count + outstanding < FIFO_DEPTH.
  - rd_addr = {BANK[BANK_WIDTH-1:0], row, col[COL_WIDTH-1:0]}.
  - Once raised, rd_req and rd_addr stay stable until rd_ack. A request is never withdrawn.
  - On rd_req && rd_ack: col increments and outstanding increments.
  - After the ack for col = WORDS_PER_LINE-1, go to DRAIN and drop rd_req in the next cycle.
  - rd_ack while rd_req is low is ignored.
- State DRAIN:
  - Wait for outstanding = 0 (after counting that cycle's decrement).
  - Then pulse line_done for one cycle, deassert busy in the same cycle, and return to IDLE.
  - line_start is accepted again from the following cycle.
- line_start while busy is ignored. No queueing; line_y and offset are not resampled.
- Returns:
  - rd_valid with outstanding > 0 pushes rd_data into the FIFO and decrements outstanding.
  - rd_valid with outstanding = 0 is dropped.
  - Acknowledge and return in the same cycle: outstanding is unchanged (net +1-1).
- FIFO:
  - Registered storage. Data written in cycle N is visible on pix_data with pix_valid in cycle N+1.
  - Pop on pix_valid && pix_ready.
  - Simultaneous push and pop: count unchanged; legal even when full or empty+1.
  - The credit rule guarantees no push into a full FIFO, so no overflow path is needed.
  - The FIFO is not flushed between lines; leftover words drain normally.
- Counters:
  - outstanding and fifo_count are sized to hold FIFO_DEPTH.
  - col is sized to hold WORDS_PER_LINE.

Optional Feature:
- Macro: ADDR_READER_UNDERRUN_EN.
- When defined:
  - Extra output underrun (1 bit, reset 0).
  - Sticky set in any cycle where busy && pix_ready && !pix_valid.
  - Cleared only by rst or by an accepted line_start.
- When undefined: the port and logic are absent; interface and behaviour are otherwise identical.

Test Plan:
- Basic line: WORDS_PER_LINE=4, line_y=5, offset=3, rd_ack tied 1, rd_valid 2 cycles after each ack, pix_ready=1 -> rd_addr sequence {1,8,0..3}, i.e. 0x41000..0x41003; pix_data in order; one line_done pulse; busy low afterwards.
- Row wrap: line_y=500, offset=20 -> row field = 8; address 0x41000 for col 0.
- Backpressure: pix_ready=0, FIFO_DEPTH=8, WORDS_PER_LINE=16 -> exactly 8 acks, then rd_req held low. Raising pix_ready resumes issue; all 16 words delivered in order.
- Stall: rd_ack held 0 for 5 cycles -> rd_req and rd_addr stable all 5 cycles; col does not advance.
- Reset mid-line: assert rst after 2 acks, then apply a stray rd_valid -> all outputs 0, pix_valid stays 0, no line_done; a new line_start then fetches correctly from col 0.
- Ignored start / underrun: line_start pulsed while busy -> no effect. With ADDR_READER_UNDERRUN_EN, pix_ready=1 while FIFO is empty during a line -> underrun=1 until the next line_start.

Source files
------------

// File: rtl/addr_reader_if.sv
// addr_reader_if: line control, SDRAM read and pixel stream signals of addr_reader.
// Carries the underrun flag when ADDR_READER_UNDERRUN_EN is defined.
interface addr_reader_if #(
  parameter int HADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  logic line_start;
  logic [9:0] line_y;
  logic [9:0] offset;
  logic busy;
  logic line_done;
  logic rd_req;
  logic [HADDR_WIDTH-1:0] rd_addr;
  logic rd_ack;
  logic rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic pix_ready;
`ifdef ADDR_READER_UNDERRUN_EN
  logic underrun;
  modport master (
    input line_start, line_y, offset, rd_ack, rd_valid, rd_data, pix_ready,
    output busy, line_done, rd_req, rd_addr, pix_valid, pix_data, underrun
  );
  modport slave (
    output line_start, line_y, offset, rd_ack, rd_valid, rd_data, pix_ready,
    input busy, line_done, rd_req, rd_addr, pix_valid, pix_data, underrun
  );
`else
  modport master (
    input line_start, line_y, offset, rd_ack, rd_valid, rd_data, pix_ready,
    output busy, line_done, rd_req, rd_addr, pix_valid, pix_data
  );
  modport slave (
    output line_start, line_y, offset, rd_ack, rd_valid, rd_data, pix_ready,
    input busy, line_done, rd_req, rd_addr, pix_valid, pix_data
  );
`endif
endinterface

// File: rtl/addr_reader.sv
// addr_reader: fetches one scanline of pixel words from SDRAM into a return FIFO for VGA scanout.
// Defining ADDR_READER_UNDERRUN_EN adds a sticky underrun flag.
module addr_reader #(
  parameter int ROW_WIDTH = 9,
  parameter int COL_WIDTH = 9,
  parameter int BANK_WIDTH = 2,
  parameter int BANK = 1,
  parameter int HADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH,
  parameter int DATA_WIDTH = 16,
  parameter int WORDS_PER_LINE = 320,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic rst,
  addr_reader_if.master bus
);
  localparam int CW = $clog2(WORDS_PER_LINE + 1);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [ROW_WIDTH-1:0] row, row_sum;
  logic [CW-1:0] col;
  logic [OW-1:0] outstanding, outstanding_next, count;
  logic [AW-1:0] wp, rp;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic start, credit, req, ack, push, pop, busy, line_done;
  assign row_sum = ROW_WIDTH'(bus.line_y + bus.offset);
  assign start = state == IDLE && bus.line_start;
  // in-flight words count against FIFO space so a return can never find the FIFO full
  assign credit = {1'b0, count} + {1'b0, outstanding} < (OW + 1)'(FIFO_DEPTH);
  assign req = state == ISSUE && credit;
  assign ack = req && bus.rd_ack;
  assign push = bus.rd_valid && outstanding != '0;
  assign pop = count != '0 && bus.pix_ready;
  assign outstanding_next = outstanding + OW'(ack) - OW'(push);
  assign bus.rd_req = req;
  assign bus.rd_addr = req ? HADDR_WIDTH'({BANK_WIDTH'(BANK), row, COL_WIDTH'(col)}) : '0;
  assign bus.pix_valid = count != '0;
  assign bus.pix_data = count != '0 ? mem[rp] : '0;
  assign bus.busy = busy;
  assign bus.line_done = line_done;
  always_ff @(posedge clk) if (push) mem[wp] <= bus.rd_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      outstanding <= '0;
      count <= '0;
      wp <= '0;
      rp <= '0;
      busy <= 1'b0;
      line_done <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      count <= count + OW'(push) - OW'(pop);
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      line_done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          row <= row_sum;
          col <= '0;
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (ack) begin
          col <= col + CW'(1);
          if (col == CW'(WORDS_PER_LINE - 1)) state <= DRAIN;
        end
        DRAIN: if (outstanding_next == '0) begin
          state <= IDLE;
          busy <= 1'b0;
          line_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef ADDR_READER_UNDERRUN_EN
  logic underrun;
  assign bus.underrun = underrun;
  always_ff @(posedge clk)
    underrun <= rst || start ? 1'b0 : underrun || (busy && bus.pix_ready && count == '0);
`endif
endmodule
